// File: rtl/cardinal_nic_port.sv
// Single-entry NIC between a processor register port and a ring router: one input and one output packet buffer.
// Capture/load take effect at the next edge and a send can follow one cycle after a load; a full buffer refuses new data (net_ri=0, OUT_BUF writes dropped).
module cardinal_nic_port #(
  parameter int VC_BIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:1]  addr,
  input  logic [0:63] d_in,
  output logic [0:63] d_out,
  input  logic        nicEn,
  input  logic        nicWrEn,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do,
  input  logic        net_polarity
);

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  logic [0:63] ibuf_q, ibuf_d;
  logic [0:63] obuf_q, obuf_d;
  logic        in_full_q, in_full_d;
  logic        out_full_q, out_full_d;

  logic rd_en;
  logic wr_en;
  logic in_capture;
  logic in_consume;
  logic out_load;

  always_comb begin
    rd_en  = nicEn & ~nicWrEn;
    wr_en  = nicEn & nicWrEn;

    net_ri = ~in_full_q;
    net_do = obuf_q;
    // A packet only leaves on the ring phase matching its VC bit.
    net_so = out_full_q & net_ro & (obuf_q[VC_BIT] == net_polarity);

    in_capture = net_si & ~in_full_q;
    in_consume = rd_en & (addr == ADDR_IN_BUF) & in_full_q;
    out_load   = wr_en & (addr == ADDR_OUT_BUF) & ~out_full_q;

    ibuf_d     = ibuf_q;
    in_full_d  = in_full_q;
    obuf_d     = obuf_q;
    out_full_d = out_full_q;

    // Capture needs an empty buffer and consume needs a full one, so they never coincide.
    if (in_capture) begin
      ibuf_d    = net_di;
      in_full_d = 1'b1;
    end else if (in_consume) begin
      in_full_d = 1'b0;
    end

    if (out_load) begin
      obuf_d     = d_in;
      out_full_d = 1'b1;
    end else if (net_so) begin
      out_full_d = 1'b0;
    end

    d_out = '0;
    if (rd_en) begin
      case (addr)
        ADDR_IN_BUF:   d_out = ibuf_q;
        ADDR_IN_STAT:  d_out = {63'b0, in_full_q};
        ADDR_OUT_STAT: d_out = {63'b0, out_full_q};
        default:       d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ibuf_q     <= '0;
      obuf_q     <= '0;
      in_full_q  <= 1'b0;
      out_full_q <= 1'b0;
    end else begin
      ibuf_q     <= ibuf_d;
      obuf_q     <= obuf_d;
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic_port.sv
// Directed bench for cardinal_nic_port: a vector table for cycle-by-cycle checks plus two multi-cycle sequences.
module tb_cardinal_nic_port;

  logic        clk;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  cardinal_nic_port #(.VC_BIT(0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        we;
    logic [1:0]  a;
    logic [63:0] din;
    logic        si;
    logic [63:0] di;
    logic        ro;
    logic        pol;
    logic        chk;
    logic        ri;
    logic        so;
    logic [63:0] do_e;
    logic [63:0] dout_e;
  } vec_t;

  vec_t tbl[$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(logic rst, logic en, logic we, logic [1:0] a, logic [63:0] din,
                              logic si, logic [63:0] di, logic ro, logic pol, logic chk,
                              logic ri, logic so, logic [63:0] do_e, logic [63:0] dout_e);
    vec_t v;
    v.rst = rst; v.en = en; v.we = we; v.a = a; v.din = din; v.si = si; v.di = di;
    v.ro = ro; v.pol = pol; v.chk = chk; v.ri = ri; v.so = so; v.do_e = do_e; v.dout_e = dout_e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic we, input logic [1:0] a,
                       input logic [63:0] din, input logic si, input logic [63:0] di,
                       input logic ro, input logic pol);
    reset = rst; nicEn = en; nicWrEn = we; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
  endtask

  localparam logic [63:0] MSB1 = 64'h8000_0000_0000_0000;

  initial begin
    int first_so;
    int pulses;

    //              rst en we addr  d_in          si di      ro pol chk ri so net_do        d_out
    tbl.push_back(mk(0, 0, 0, 2'b00, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, 64'h0,        64'h0));
    tbl.push_back(mk(0, 1, 1, 2'b10, 64'hA5,       0, 64'h0,  1, 0,  1, 1, 0, 64'h0,        64'h0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 64'h0,        0, 64'h0,  1, 0,  1, 1, 1, 64'hA5,       64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b11, 64'h0,        0, 64'h0,  1, 0,  1, 1, 0, 64'hA5,       64'h0));
    tbl.push_back(mk(0, 1, 1, 2'b10, MSB1,         0, 64'h0,  1, 0,  1, 1, 0, 64'hA5,       64'h0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 64'h0,        0, 64'h0,  1, 0,  1, 1, 0, MSB1,         64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b11, 64'h0,        0, 64'h0,  1, 0,  1, 1, 0, MSB1,         64'h1));
    tbl.push_back(mk(0, 0, 0, 2'b00, 64'h0,        0, 64'h0,  1, 0,  1, 1, 0, MSB1,         64'h0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 64'h0,        0, 64'h0,  1, 1,  1, 1, 1, MSB1,         64'h0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 64'h0,        0, 64'h0,  1, 1,  1, 1, 0, MSB1,         64'h0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 64'h0,        1, 64'h1234, 0, 0, 1, 1, 0, MSB1,         64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 64'h0,        1, 64'hBEEF, 0, 0, 1, 0, 0, MSB1,         64'h1));
    tbl.push_back(mk(0, 1, 0, 2'b00, 64'h0,        1, 64'hBEEF, 0, 0, 1, 0, 0, MSB1,         64'h1234));
    tbl.push_back(mk(0, 0, 0, 2'b00, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, MSB1,         64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, MSB1,         64'h1234));
    tbl.push_back(mk(0, 1, 0, 2'b01, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, MSB1,         64'h0));
    tbl.push_back(mk(0, 1, 1, 2'b10, 64'h1,        0, 64'h0,  0, 0,  1, 1, 0, MSB1,         64'h0));
    tbl.push_back(mk(0, 1, 1, 2'b10, 64'h2,        0, 64'h0,  0, 0,  1, 1, 0, 64'h1,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b11, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, 64'h1,        64'h1));
    tbl.push_back(mk(0, 1, 1, 2'b10, 64'h3,        0, 64'h0,  1, 0,  1, 1, 1, 64'h1,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b11, 64'h0,        0, 64'h0,  1, 0,  1, 1, 0, 64'h1,        64'h0));
    tbl.push_back(mk(0, 1, 1, 2'b00, 64'hFFFF,     0, 64'h0,  0, 0,  1, 1, 0, 64'h1,        64'h0));
    tbl.push_back(mk(0, 1, 1, 2'b11, 64'hFFFF,     0, 64'h0,  0, 0,  1, 1, 0, 64'h1,        64'h0));
    tbl.push_back(mk(0, 1, 1, 2'b01, 64'hFFFF,     0, 64'h0,  0, 0,  1, 1, 0, 64'h1,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, 64'h1,        64'h1234));
    tbl.push_back(mk(0, 1, 0, 2'b11, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, 64'h1,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b10, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, 64'h1,        64'h0));
    tbl.push_back(mk(0, 1, 1, 2'b10, 64'hAA,       1, 64'h55, 0, 0,  1, 1, 0, 64'h1,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 64'h0,        0, 64'h0,  0, 0,  1, 0, 0, 64'hAA,       64'h1));
    // Reset lands on a pending send, a read-clear and a refused offer all at once.
    tbl.push_back(mk(1, 1, 0, 2'b00, 64'h0,        1, 64'h77, 1, 0,  0, 0, 0, 64'h0,        64'h0));
    tbl.push_back(mk(0, 0, 0, 2'b00, 64'h0,        0, 64'h0,  1, 0,  1, 1, 0, 64'h0,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, 64'h0,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b11, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, 64'h0,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b01, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, 64'h0,        64'h0));
    // Reset must swallow a load and a capture on an empty NIC.
    tbl.push_back(mk(1, 1, 1, 2'b10, 64'hFF,       1, 64'h99, 1, 0,  0, 0, 0, 64'h0,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b11, 64'h0,        0, 64'h0,  1, 0,  1, 1, 0, 64'h0,        64'h0));
    tbl.push_back(mk(0, 1, 0, 2'b00, 64'h0,        0, 64'h0,  0, 0,  1, 1, 0, 64'h0,        64'h0));

    drive(1, 0, 0, 2'b00, 64'h0, 0, 64'h0, 0, 0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].en, tbl[i].we, tbl[i].a, tbl[i].din,
            tbl[i].si, tbl[i].di, tbl[i].ro, tbl[i].pol);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("v%0d_net_ri", i), {63'b0, net_ri}, {63'b0, tbl[i].ri});
        check($sformatf("v%0d_net_so", i), {63'b0, net_so}, {63'b0, tbl[i].so});
        check($sformatf("v%0d_net_do", i), net_do, tbl[i].do_e);
        check($sformatf("v%0d_d_out", i), d_out, tbl[i].dout_e);
      end
    end

    // Offer rejected during a read-clear is accepted on the very next cycle.
    @(negedge clk); drive(0, 0, 0, 2'b00, 64'h0, 1, 64'h1234, 0, 0);
    @(negedge clk); drive(0, 1, 0, 2'b00, 64'h0, 1, 64'hBEEF, 0, 0);
    #1;
    check("seq_clear_ri", {63'b0, net_ri}, 64'h0);
    check("seq_clear_dout", d_out, 64'h1234);
    @(negedge clk); drive(0, 0, 0, 2'b00, 64'h0, 1, 64'hBEEF, 0, 0);
    #1;
    check("seq_reoffer_ri", {63'b0, net_ri}, 64'h1);
    @(negedge clk); drive(0, 1, 0, 2'b00, 64'h0, 0, 64'h0, 0, 0);
    #1;
    check("seq_second_pkt", d_out, 64'hBEEF);
    check("seq_second_ri", {63'b0, net_ri}, 64'h0);

    // Mismatched VC waits for the polarity flip; send pulses exactly once within a bounded window.
    @(negedge clk); drive(0, 1, 1, 2'b10, MSB1, 0, 64'h0, 1, 0);
    first_so = -1;
    pulses   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 2'b00, 64'h0, 0, 64'h0, 1, (c >= 5));
      #1;
      if (net_so) begin
        pulses++;
        if (first_so < 0) first_so = c;
      end
    end
    check("seq_vc_first_so", 64'(first_so), 64'd5);
    check("seq_vc_pulses", 64'(pulses), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
